// File: rtl/ltpi_phy_rx_deframer_if.sv
// LTPI PHY RX deframer: base frame type plus the symbol-in / frame-out bundle
// shared by the deframer and whatever drives it.

typedef struct packed {
  logic [7:0]       comma;
  logic [7:0]       subtype;
  logic [12:0][7:0] data;
  logic [7:0]       crc;
} LTPI_base_Frm_t;

interface ltpi_phy_rx_deframer_if;
  logic           sym_valid;
  logic [7:0]     sym_data;
  logic           sym_k;
  logic           sym_code_err;
  LTPI_base_Frm_t ltpi_frame_rx;
  logic           rx_frm_valid;
  logic           rx_frm_err;
  logic [3:0]     rx_frm_offset;
  logic           aligned;
  logic [15:0]    crc_err_cnt;

  // Symbol source side (8b10b decoder model or testbench)
  modport master (
    output sym_valid, sym_data, sym_k, sym_code_err,
    input  ltpi_frame_rx, rx_frm_valid, rx_frm_err, rx_frm_offset, aligned, crc_err_cnt
  );

  // Deframer side
  modport slave (
    input  sym_valid, sym_data, sym_k, sym_code_err,
    output ltpi_frame_rx, rx_frm_valid, rx_frm_err, rx_frm_offset, aligned, crc_err_cnt
  );
endinterface

// File: rtl/ltpi_phy_rx_deframer.sv
// LTPI PHY RX deframer: finds the comma in the decoded symbol stream, rebuilds
// 16-byte base frames, checks CRC-8 (poly 0x07, init 0, MSB-first), tracks
// frame lock and counts bad frames.

module ltpi_phy_rx_deframer #(
  parameter logic [7:0] COMMA_A     = 8'hBC,
  parameter logic [7:0] COMMA_B     = 8'hDC,
  parameter int         LOCK_THRESH = 3,
  parameter int         LOSS_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  ltpi_phy_rx_deframer_if.slave rx_if
);

  localparam int RUN_MAX = (LOCK_THRESH > LOSS_THRESH) ? LOCK_THRESH : LOSS_THRESH;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    RECV   = 2'd1,
    EXPECT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [14:0][7:0] r_buf;
  logic [3:0]       r_offset;
  logic [7:0]       r_crc;
  logic             r_marked;

  LTPI_base_Frm_t   r_frame;
  LTPI_base_Frm_t   w_assembled;
  logic             r_valid_pls;
  logic             r_err_pls;

  logic             r_aligned;
  logic [15:0]      r_err_cnt;
  logic [RUN_W-1:0] r_good_run;
  logic [RUN_W-1:0] r_bad_run;
  logic [RUN_W-1:0] w_good_run_nxt;
  logic [RUN_W-1:0] w_bad_run_nxt;

  logic             w_comma;
  logic [3:0]       w_next_off;
  logic             w_start;
  logic             w_store;
  logic             w_fold;
  logic             w_mark;
  logic             w_good_evt;
  logic             w_bad_evt;

  // One byte of CRC-8, polynomial x^8+x^2+x+1, MSB first, no reflection
  function automatic logic [7:0] crc8(input logic [7:0] crc_in, input logic [7:0] data_in);
    logic [7:0] c;
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign w_comma    = rx_if.sym_valid & rx_if.sym_k & ~rx_if.sym_code_err &
                      ((rx_if.sym_data == COMMA_A) | (rx_if.sym_data == COMMA_B));
  assign w_next_off = r_offset + 4'd1;

  // Next-state and per-symbol action decode; a comma always (re)starts a frame
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_store     = 1'b0;
    w_fold      = 1'b0;
    w_mark      = 1'b0;
    w_good_evt  = 1'b0;
    w_bad_evt   = 1'b0;
    if (rx_if.sym_valid) begin
      case (r_state)
        HUNT: begin
          if (w_comma) begin
            w_start     = 1'b1;
            w_state_nxt = RECV;
          end
        end
        RECV: begin
          if (w_comma) begin
            w_start   = 1'b1;
            w_bad_evt = 1'b1;
          end else begin
            w_store = 1'b1;
            if (w_next_off == 4'd15) begin
              if (!r_marked && !rx_if.sym_k && (rx_if.sym_data == r_crc)) begin
                w_good_evt = 1'b1;
              end else begin
                w_bad_evt = 1'b1;
              end
              w_state_nxt = EXPECT;
            end else begin
              w_fold = 1'b1;
              w_mark = rx_if.sym_k | rx_if.sym_code_err;
            end
          end
        end
        EXPECT: begin
          if (w_comma) begin
            w_start     = 1'b1;
            w_state_nxt = RECV;
          end else begin
            w_bad_evt   = 1'b1;
            w_state_nxt = HUNT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame assembly buffer, byte offset, running CRC and the frame-bad mark
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf    <= '0;
      r_offset <= 4'hF;
      r_crc    <= 8'h00;
      r_marked <= 1'b0;
    end else if (w_start) begin
      r_buf[0] <= rx_if.sym_data;
      r_offset <= 4'd0;
      r_crc    <= crc8(8'h00, rx_if.sym_data);
      r_marked <= 1'b0;
    end else if (w_store) begin
      r_offset <= w_next_off;
      if (w_fold) begin
        r_buf[w_next_off] <= rx_if.sym_data;
        r_crc             <= crc8(r_crc, rx_if.sym_data);
      end
      if (w_mark) begin
        r_marked <= 1'b1;
      end
    end
  end

  // Completed frame view: buffered bytes 0..14 plus the CRC byte arriving now
  always_comb begin
    w_assembled         = '0;
    w_assembled.comma   = r_buf[0];
    w_assembled.subtype = r_buf[1];
    for (int i = 0; i < 13; i++) begin
      w_assembled.data[4'(i)] = r_buf[4'(i + 2)];
    end
    w_assembled.crc     = rx_if.sym_data;
  end

  // Frame completion pulses; the held frame only changes on a good frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame     <= '0;
      r_valid_pls <= 1'b0;
      r_err_pls   <= 1'b0;
    end else begin
      r_valid_pls <= w_good_evt;
      r_err_pls   <= w_bad_evt;
      if (w_good_evt) begin
        r_frame <= w_assembled;
      end
    end
  end

  // Saturating increments of the good/bad run counters
  always_comb begin
    w_good_run_nxt = (r_good_run == RUN_W'(LOCK_THRESH)) ? r_good_run : r_good_run + 1'b1;
    w_bad_run_nxt  = (r_bad_run == RUN_W'(LOSS_THRESH)) ? r_bad_run : r_bad_run + 1'b1;
  end

  // Lock hysteresis and saturating bad-frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_good_run <= '0;
      r_bad_run  <= '0;
      r_aligned  <= 1'b0;
      r_err_cnt  <= 16'h0000;
    end else if (w_good_evt) begin
      r_good_run <= w_good_run_nxt;
      r_bad_run  <= '0;
      if (w_good_run_nxt == RUN_W'(LOCK_THRESH)) begin
        r_aligned <= 1'b1;
      end
    end else if (w_bad_evt) begin
      r_bad_run  <= w_bad_run_nxt;
      r_good_run <= '0;
      if (w_bad_run_nxt == RUN_W'(LOSS_THRESH)) begin
        r_aligned <= 1'b0;
      end
      if (r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign rx_if.ltpi_frame_rx = r_frame;
  assign rx_if.rx_frm_valid  = r_valid_pls;
  assign rx_if.rx_frm_err    = r_err_pls;
  assign rx_if.rx_frm_offset = r_offset;
  assign rx_if.aligned       = r_aligned;
  assign rx_if.crc_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ltpi_phy_rx_deframer.sv
// Self-checking bench for ltpi_phy_rx_deframer: a scoreboard of expected frame
// events (good/bad, held frame, cycle) against pulses seen on the DUT outputs.

module tb_ltpi_phy_rx_deframer;

  typedef logic [7:0] frm_bytes_t [16];

  typedef struct {
    bit             good;
    bit             bad;
    LTPI_base_Frm_t frame;
    int             cyc;
  } evt_t;

  logic clk = 1'b0;
  logic reset;

  ltpi_phy_rx_deframer_if rx_if ();

  ltpi_phy_rx_deframer dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  evt_t           exp_q[$];
  evt_t           obs_q[$];
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_bad = 0;
  LTPI_base_Frm_t last_good = '0;

  // Cycle counter and pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    evt_t e;
    cyc++;
    if (rx_if.rx_frm_valid || rx_if.rx_frm_err) begin
      e.good  = rx_if.rx_frm_valid;
      e.bad   = rx_if.rx_frm_err;
      e.frame = rx_if.ltpi_frame_rx;
      e.cyc   = cyc;
      obs_q.push_back(e);
    end
  end

  // Bit-serial CRC-8 (0x07) over bytes 0..14
  function automatic logic [7:0] ref_crc(input frm_bytes_t b);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int j = 0; j < 15; j++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ b[j][i];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  function automatic void make_frame(input logic [7:0] comma, input logic [7:0] sub,
                                     input logic [7:0] seed, output frm_bytes_t b);
    b[0] = comma;
    b[1] = sub;
    for (int i = 0; i < 13; i++) b[i + 2] = seed + 8'(i);
    b[15] = ref_crc(b);
  endfunction

  function automatic LTPI_base_Frm_t to_frame(input frm_bytes_t b);
    LTPI_base_Frm_t f;
    f.comma   = b[0];
    f.subtype = b[1];
    for (int i = 0; i < 13; i++) f.data[i] = b[i + 2];
    f.crc     = b[15];
    return f;
  endfunction

  task automatic drive_sym(input logic [7:0] d, input logic k, input logic e, output int c);
    @(negedge clk);
    #1;
    rx_if.sym_valid    = 1'b1;
    rx_if.sym_data     = d;
    rx_if.sym_k        = k;
    rx_if.sym_code_err = e;
    c = cyc + 1;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      rx_if.sym_valid    = 1'b0;
      rx_if.sym_data     = 8'h00;
      rx_if.sym_k        = 1'b0;
      rx_if.sym_code_err = 1'b0;
    end
  endtask

  task automatic push_evt(input bit good, input int c);
    evt_t e;
    e.good  = good;
    e.bad   = !good;
    e.frame = last_good;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input frm_bytes_t b, input int gap, input int err_at, input bit exp_good);
    int c;
    for (int i = 0; i < 16; i++) begin
      drive_sym(b[i], (i == 0), (i == err_at), c);
      if (gap > 0 && i < 15) drive_idle(gap);
    end
    if (exp_good) last_good = to_frame(b);
    push_evt(exp_good, c);
  endtask

  task automatic do_reset();
    drive_idle(1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    last_good = '0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic next_pair(output evt_t got, output evt_t want, output bit timeout);
    int guard;
    guard = 0;
    want  = exp_q.pop_front();
    while (obs_q.size() == 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    timeout = (obs_q.size() == 0);
    if (!timeout) begin
      got = obs_q.pop_front();
    end else begin
      got.good = 0; got.bad = 0; got.frame = '0; got.cyc = -1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rx_if.ltpi_frame_rx !== '0) begin n_bad++; $display("[TB] FAIL rst_frame: got %h want 0", rx_if.ltpi_frame_rx); end
    n_cmp++; if (rx_if.rx_frm_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid: got %b want 0", rx_if.rx_frm_valid); end
    n_cmp++; if (rx_if.rx_frm_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_err: got %b want 0", rx_if.rx_frm_err); end
    n_cmp++; if (rx_if.rx_frm_offset !== 4'hF) begin n_bad++; $display("[TB] FAIL rst_offset: got %h want f", rx_if.rx_frm_offset); end
    n_cmp++; if (rx_if.aligned !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_aligned: got %b want 0", rx_if.aligned); end
    n_cmp++; if (rx_if.crc_err_cnt !== 16'h0) begin n_bad++; $display("[TB] FAIL rst_cnt: got %h want 0", rx_if.crc_err_cnt); end
  endtask

  task automatic test_lock();
    frm_bytes_t b;
    evt_t got, want;
    bit to;
    do_reset();
    make_frame(8'hBC, 8'h01, 8'h00, b);
    send_frame(b, 0, -1, 1);
    send_frame(b, 0, -1, 1);
    drive_idle(2);
    n_cmp++; if (rx_if.aligned !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_early: got %b want 0", rx_if.aligned); end
    send_frame(b, 0, -1, 1);
    drive_idle(2);
    while (exp_q.size() > 0) begin
      next_pair(got, want, to);
      n_cmp++; if (to || got.good !== want.good || got.bad !== want.bad || got.cyc !== want.cyc) begin n_bad++; $display("[TB] FAIL lock_pulse: got v=%0b e=%0b cyc=%0d want v=%0b e=%0b cyc=%0d", got.good, got.bad, got.cyc, want.good, want.bad, want.cyc); end
      n_cmp++; if (got.frame !== want.frame) begin n_bad++; $display("[TB] FAIL lock_frame: got %h want %h", got.frame, want.frame); end
    end
    drive_idle(2);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("[TB] FAIL lock_extra: got %0d extra pulses want 0", obs_q.size()); end
    n_cmp++; if (rx_if.aligned !== 1'b1) begin n_bad++; $display("[TB] FAIL lock_aligned: got %b want 1", rx_if.aligned); end
    n_cmp++; if (rx_if.crc_err_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL lock_cnt: got %0d want 0", rx_if.crc_err_cnt); end
    n_cmp++; if (rx_if.ltpi_frame_rx.data[12] !== 8'h0C) begin n_bad++; $display("[TB] FAIL lock_data12: got %h want 0c", rx_if.ltpi_frame_rx.data[12]); end
    n_cmp++; if (rx_if.rx_frm_offset !== 4'hF) begin n_bad++; $display("[TB] FAIL lock_offset: got %h want f", rx_if.rx_frm_offset); end
  endtask

  task automatic test_crc_error();
    frm_bytes_t b, bb;
    evt_t got, want;
    bit to;
    make_frame(8'hBC, 8'h01, 8'h00, b);
    bb = b;
    bb[15] = bb[15] ^ 8'h01;
    send_frame(bb, 0, -1, 0);
    drive_idle(2);
    n_cmp++; if (rx_if.crc_err_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL crc_cnt: got %0d want 1", rx_if.crc_err_cnt); end
    n_cmp++; if (rx_if.aligned !== 1'b1) begin n_bad++; $display("[TB] FAIL crc_aligned: got %b want 1", rx_if.aligned); end
    make_frame(8'hDC, 8'h03, 8'h30, b);
    send_frame(b, 0, -1, 1);
    drive_idle(2);
    while (exp_q.size() > 0) begin
      next_pair(got, want, to);
      n_cmp++; if (to || got.good !== want.good || got.bad !== want.bad || got.cyc !== want.cyc) begin n_bad++; $display("[TB] FAIL crc_pulse: got v=%0b e=%0b cyc=%0d want v=%0b e=%0b cyc=%0d", got.good, got.bad, got.cyc, want.good, want.bad, want.cyc); end
      n_cmp++; if (got.frame !== want.frame) begin n_bad++; $display("[TB] FAIL crc_frame: got %h want %h", got.frame, want.frame); end
    end
    drive_idle(2);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("[TB] FAIL crc_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  task automatic test_loss_of_lock();
    frm_bytes_t b, bb;
    evt_t got, want;
    bit to;
    do_reset();
    make_frame(8'hBC, 8'h02, 8'h10, b);
    bb = b;
    bb[15] = bb[15] ^ 8'h80;
    for (int i = 0; i < 3; i++) send_frame(b, 0, -1, 1);
    drive_idle(2);
    n_cmp++; if (rx_if.aligned !== 1'b1) begin n_bad++; $display("[TB] FAIL loss_prelock: got %b want 1", rx_if.aligned); end
    send_frame(bb, 0, -1, 0);
    send_frame(bb, 0, -1, 0);
    drive_idle(2);
    n_cmp++; if (rx_if.aligned !== 1'b1) begin n_bad++; $display("[TB] FAIL loss_early: got %b want 1", rx_if.aligned); end
    send_frame(bb, 0, -1, 0);
    drive_idle(2);
    n_cmp++; if (rx_if.aligned !== 1'b0) begin n_bad++; $display("[TB] FAIL loss_aligned: got %b want 0", rx_if.aligned); end
    n_cmp++; if (rx_if.crc_err_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL loss_cnt: got %0d want 3", rx_if.crc_err_cnt); end
    send_frame(b, 0, -1, 1);
    send_frame(b, 0, -1, 1);
    drive_idle(2);
    n_cmp++; if (rx_if.aligned !== 1'b0) begin n_bad++; $display("[TB] FAIL relock_early: got %b want 0", rx_if.aligned); end
    send_frame(b, 0, -1, 1);
    drive_idle(2);
    n_cmp++; if (rx_if.aligned !== 1'b1) begin n_bad++; $display("[TB] FAIL relock_aligned: got %b want 1", rx_if.aligned); end
    while (exp_q.size() > 0) begin
      next_pair(got, want, to);
      n_cmp++; if (to || got.good !== want.good || got.bad !== want.bad || got.cyc !== want.cyc) begin n_bad++; $display("[TB] FAIL loss_pulse: got v=%0b e=%0b cyc=%0d want v=%0b e=%0b cyc=%0d", got.good, got.bad, got.cyc, want.good, want.bad, want.cyc); end
      n_cmp++; if (got.frame !== want.frame) begin n_bad++; $display("[TB] FAIL loss_frame: got %h want %h", got.frame, want.frame); end
    end
    drive_idle(2);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("[TB] FAIL loss_extra: got %0d extra pulses want 0", obs_q.size()); end
  endtask

  task automatic test_early_comma();
    frm_bytes_t b;
    evt_t got, want;
    bit to;
    int c;
    make_frame(8'hBC, 8'h05, 8'h20, b);
    for (int i = 0; i < 7; i++) drive_sym(b[i], (i == 0), 1'b0, c);
    drive_sym(8'hBC, 1'b1, 1'b0, c);
    push_evt(1'b0, c);
    drive_idle(1);
    n_cmp++; if (rx_if.rx_frm_offset !== 4'd0) begin n_bad++; $display("[TB] FAIL early_offset: got %0d want 0", rx_if.rx_frm_offset); end
    n_cmp++; if (rx_if.crc_err_cnt !== 16'd4) begin n_bad++; $display("[TB] FAIL early_cnt: got %0d want 4", rx_if.crc_err_cnt); end
    for (int i = 1; i < 16; i++) drive_sym(b[i], 1'b0, 1'b0, c);
    last_good = to_frame(b);
    push_evt(1'b1, c);
    drive_idle(2);
    while (exp_q.size() > 0) begin
      next_pair(got, want, to);
      n_cmp++; if (to || got.good !== want.good || got.bad !== want.bad || got.cyc !== want.cyc) begin n_bad++; $display("[TB] FAIL early_pulse: got v=%0b e=%0b cyc=%0d want v=%0b e=%0b cyc=%0d", got.good, got.bad, got.cyc, want.good, want.bad, want.cyc); end
      n_cmp++; if (got.frame !== want.frame) begin n_bad++; $display("[TB] FAIL early_frame: got %h want %h", got.frame, want.frame); end
    end
    drive_idle(2);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("[TB] FAIL early_extra: got %0d extra pulses want 0", obs_q.size()); end
    n_cmp++; if (rx_if.crc_err_cnt !== 16'd4) begin n_bad++; $display("[TB] FAIL early_cnt_end: got %0d want 4", rx_if.crc_err_cnt); end
  endtask

  task automatic test_code_err_gaps();
    frm_bytes_t b;
    evt_t got, want;
    bit to;
    make_frame(8'hBC, 8'h07, 8'h40, b);
    send_frame(b, 2, 5, 0);
    make_frame(8'hDC, 8'h08, 8'h50, b);
    send_frame(b, 1, -1, 1);
    drive_idle(2);
    while (exp_q.size() > 0) begin
      next_pair(got, want, to);
      n_cmp++; if (to || got.good !== want.good || got.bad !== want.bad || got.cyc !== want.cyc) begin n_bad++; $display("[TB] FAIL cerr_pulse: got v=%0b e=%0b cyc=%0d want v=%0b e=%0b cyc=%0d", got.good, got.bad, got.cyc, want.good, want.bad, want.cyc); end
      n_cmp++; if (got.frame !== want.frame) begin n_bad++; $display("[TB] FAIL cerr_frame: got %h want %h", got.frame, want.frame); end
    end
    drive_idle(2);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("[TB] FAIL cerr_extra: got %0d extra pulses want 0", obs_q.size()); end
    n_cmp++; if (rx_if.crc_err_cnt !== 16'd5) begin n_bad++; $display("[TB] FAIL cerr_cnt: got %0d want 5", rx_if.crc_err_cnt); end
  endtask

  task automatic test_reset_and_saturation();
    frm_bytes_t b;
    evt_t got, want;
    bit to;
    int c;
    make_frame(8'hBC, 8'h09, 8'h60, b);
    for (int i = 0; i < 10; i++) drive_sym(b[i], (i == 0), 1'b0, c);
    do_reset();
    n_cmp++; if (rx_if.ltpi_frame_rx !== '0) begin n_bad++; $display("[TB] FAIL mrst_frame: got %h want 0", rx_if.ltpi_frame_rx); end
    n_cmp++; if (rx_if.rx_frm_offset !== 4'hF) begin n_bad++; $display("[TB] FAIL mrst_offset: got %h want f", rx_if.rx_frm_offset); end
    n_cmp++; if (rx_if.aligned !== 1'b0) begin n_bad++; $display("[TB] FAIL mrst_aligned: got %b want 0", rx_if.aligned); end
    n_cmp++; if (rx_if.crc_err_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL mrst_cnt: got %0d want 0", rx_if.crc_err_cnt); end
    for (int i = 10; i < 16; i++) drive_sym(b[i], 1'b0, 1'b0, c);
    drive_idle(2);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("[TB] FAIL mrst_discard: got %0d pulses want 0", obs_q.size()); end
    n_cmp++; if (rx_if.rx_frm_offset !== 4'hF) begin n_bad++; $display("[TB] FAIL mrst_hunt: got %h want f", rx_if.rx_frm_offset); end
    make_frame(8'hBC, 8'h0A, 8'h70, b);
    send_frame(b, 0, -1, 1);
    for (int i = 0; i < 1001; i++) begin
      drive_sym(8'hBC, 1'b1, 1'b0, c);
      if (i > 0) push_evt(1'b0, c);
    end
    drive_idle(1);
    n_cmp++; if (rx_if.crc_err_cnt !== 16'd1000) begin n_bad++; $display("[TB] FAIL sat_mid: got %0d want 1000", rx_if.crc_err_cnt); end
    for (int i = 0; i < 64540; i++) begin
      drive_sym(8'hBC, 1'b1, 1'b0, c);
      push_evt(1'b0, c);
    end
    drive_idle(2);
    while (exp_q.size() > 0) begin
      next_pair(got, want, to);
      n_cmp++; if (to || got.good !== want.good || got.bad !== want.bad || got.cyc !== want.cyc) begin n_bad++; $display("[TB] FAIL sat_pulse: got v=%0b e=%0b cyc=%0d want v=%0b e=%0b cyc=%0d", got.good, got.bad, got.cyc, want.good, want.bad, want.cyc); end
      n_cmp++; if (got.frame !== want.frame) begin n_bad++; $display("[TB] FAIL sat_frame: got %h want %h", got.frame, want.frame); end
    end
    drive_idle(2);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("[TB] FAIL sat_extra: got %0d extra pulses want 0", obs_q.size()); end
    n_cmp++; if (rx_if.crc_err_cnt !== 16'hFFFF) begin n_bad++; $display("[TB] FAIL sat_cnt: got %h want ffff", rx_if.crc_err_cnt); end
    n_cmp++; if (rx_if.aligned !== 1'b0) begin n_bad++; $display("[TB] FAIL sat_aligned: got %b want 0", rx_if.aligned); end
  endtask

  initial begin
    reset              = 1'b1;
    rx_if.sym_valid    = 1'b0;
    rx_if.sym_data     = 8'h00;
    rx_if.sym_k        = 1'b0;
    rx_if.sym_code_err = 1'b0;
    test_reset();
    test_lock();
    test_crc_error();
    test_loss_of_lock();
    test_early_comma();
    test_code_err_gaps();
    test_reset_and_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
